// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter - round-robin share of one combinational ALU between two
// requesters; optional ALU_SHARE_STATS_EN adds grant/conflict counters. Rev 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_data1,
  input  logic [WORD_W-1:0] req0_data2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_data1,
  input  logic [WORD_W-1:0] req1_data2,
  input  logic [OP_W-1:0]   req1_op,
  output logic [WORD_W-1:0] alu_data1,
  output logic [WORD_W-1:0] alu_data2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [WORD_W-1:0] alu_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_result,
  input  logic              rsp_ready
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [OP_W-1:0] NO_OP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic open;
  logic grant_vld;
  logic grant;
  logic grant_id;
  logic last_grant;
  logic accept;
  logic tie;

  // Accept window: idle, or the held response is leaving this very cycle.
  always_comb begin
    open      = (state == IDLE) || ((state == RESP) && rsp_ready);
    tie       = req0_valid && req1_valid;
    grant_vld = 1'b0;
    grant     = 1'b0;
    if (open) begin
      if (tie) begin
        grant_vld = 1'b1;
        grant     = ~last_grant;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant     = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant     = 1'b1;
      end
    end
  end

  assign accept     = grant_vld;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = accept ? EXEC : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data1  <= '0;
      alu_data2  <= '0;
      alu_op     <= NO_OP;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        alu_data1  <= grant ? req1_data1 : req0_data1;
        alu_data2  <= grant ? req1_data2 : req0_data2;
        alu_op     <= grant ? req1_op    : req0_op;
        grant_id   <= grant;
        last_grant <= grant;
      end
      // The ALU result is valid during the single EXEC cycle only.
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_id     <= grant_id;
        rsp_valid  <= 1'b1;
        alu_op     <= NO_OP;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0   <= 16'd0;
      grant_cnt1   <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (req0_ready && (grant_cnt0 != 16'hFFFF)) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (req1_ready && (grant_cnt1 != 16'hFFFF)) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
      if (open && tie && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));
  a_ready_open: assert property (@(posedge clk) disable iff (rst)
    (req0_ready || req1_ready) |-> open);

endmodule
`default_nettype wire
